// File: rtl/conv_stream_mf.sv
// Streaming KxK convolution over an IM_DIM x IM_DIM raster frame, N_FILT filters in parallel,
// with valid/ready backpressure, per-frame kernel capture, requantisation, optional ReLU and saturation.

module conv_stream_mf_lane #(
    parameter int PIX_W = 8,
    parameter int W_W   = 12,
    parameter int K2    = 9,
    parameter int OUT_W = 8,
    parameter int SHIFT = 8,
    parameter int ACC_W = 25
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       ld_s1,
    input  logic                       ld_s2,
    input  logic [K2-1:0][PIX_W-1:0]   taps,
    input  logic [K2-1:0][W_W-1:0]     wts,
    input  logic                       relu,
    output logic [OUT_W-1:0]           y
);
    localparam int PW = PIX_W + W_W + 1;
    localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'(2**(OUT_W-1) - 1);
    localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;

    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] sum, acc_q, shd;
    logic [OUT_W-1:0]        y_d;

    // Pixels are unsigned: zero-extend before the signed multiply.
    always_comb begin
        sum  = '0;
        prod = '0;
        for (int t = 0; t < K2; t++) begin
            prod = PW'($signed({1'b0, taps[t]})) * PW'($signed(wts[t]));
            sum  = sum + ACC_W'(prod);
        end
    end

    always_comb begin
        shd = acc_q >>> SHIFT;
        y_d = shd[OUT_W-1:0];
        if (relu && shd < 0)  y_d = '0;
        else if (shd > Y_MAX) y_d = Y_MAX[OUT_W-1:0];
        else if (shd < Y_MIN) y_d = Y_MIN[OUT_W-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
            y     <= '0;
        end else begin
            if (ld_s1) acc_q <= sum;
            if (ld_s2) y     <= y_d;
        end
    end
endmodule

module conv_stream_mf #(
    parameter int PIX_W  = 8,
    parameter int W_W    = 12,
    parameter int IM_DIM = 28,
    parameter int K_DIM  = 3,
    parameter int N_FILT = 4,
    parameter int OUT_W  = 8,
    parameter int SHIFT  = 8
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [N_FILT*K_DIM*K_DIM*W_W-1:0]  k_val_i,
    input  logic                               relu_en_i,
    input  logic [PIX_W-1:0]                   pixel_i,
    input  logic                               pix_valid_i,
    output logic                               pix_ready_o,
    output logic [N_FILT*OUT_W-1:0]            pixel_o,
    output logic                               out_valid_o,
    input  logic                               out_ready_i,
    output logic                               frame_done_o
);
    localparam int K2     = K_DIM * K_DIM;
    localparam int ACC_W  = PIX_W + W_W + $clog2(K2) + 1;
    localparam int CW     = $clog2(IM_DIM);
    localparam int N_OUT  = (IM_DIM - K_DIM + 1) ** 2;
    localparam int OCW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int STAGES = 2;

    typedef struct packed {
        logic                                  relu;
        logic [N_FILT-1:0][K2-1:0][W_W-1:0]    k;
    } cfg_t;

    logic                              en, take, last_col, last_row, win_vld, hs;
    logic [CW-1:0]                     col, row;
    logic [OCW-1:0]                    ocnt;
    cfg_t                              cfg_q;
    logic                              s1_relu;
    logic [STAGES:1]                   vld_pipe;
    logic [PIX_W-1:0]                  lbuf [K_DIM-1][IM_DIM];
    logic [K_DIM-1:0][K_DIM-2:0][PIX_W-1:0] win;
    logic [K_DIM-1:0][PIX_W-1:0]       ncol;
    logic [K2-1:0][PIX_W-1:0]          taps;
    logic [N_FILT-1:0][OUT_W-1:0]      y_all;

    assign en          = ~out_valid_o | out_ready_i;
    assign pix_ready_o = en;
    assign take        = pix_valid_i & en;
    assign last_col    = (col == CW'(IM_DIM - 1));
    assign last_row    = (row == CW'(IM_DIM - 1));
    assign win_vld     = take && (row >= CW'(K_DIM - 1)) && (col >= CW'(K_DIM - 1));
    assign hs          = out_valid_o & out_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col <= '0;
            row <= '0;
        end else if (take) begin
            col <= last_col ? '0 : col + 1'b1;
            if (last_col) row <= last_row ? '0 : row + 1'b1;
        end
    end

    // Kernel and ReLU mode are frozen for the whole frame at its first pixel.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_q <= '0;
        end else if (take && col == '0 && row == '0) begin
            cfg_q.k    <= k_val_i;
            cfg_q.relu <= relu_en_i;
        end
    end

    // Line buffers indexed by column: lbuf[k][col] holds row-1-k at this column.
    always_ff @(posedge clk_i) begin
        if (take) begin
            lbuf[0][col] <= pixel_i;
            for (int k = 1; k < K_DIM - 1; k++) lbuf[k][col] <= lbuf[k-1][col];
        end
    end

    always_comb begin
        ncol          = '0;
        ncol[K_DIM-1] = pixel_i;
        for (int k = 0; k < K_DIM - 1; k++) ncol[K_DIM-2-k] = lbuf[k][col];
    end

    // Only K_DIM-1 window columns are stored; the newest column comes straight from ncol
    // so the accumulator sees the full window in the accept cycle.
    always_ff @(posedge clk_i) begin
        if (take) begin
            for (int r = 0; r < K_DIM; r++) begin
                for (int c = 0; c < K_DIM - 2; c++) win[r][c] <= win[r][c+1];
                win[r][K_DIM-2] <= ncol[r];
            end
        end
    end

    always_comb begin
        taps = '0;
        for (int r = 0; r < K_DIM; r++) begin
            for (int c = 0; c < K_DIM - 1; c++) taps[r*K_DIM+c] = win[r][c];
            taps[r*K_DIM+K_DIM-1] = ncol[r];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_pipe <= '0;
            s1_relu  <= 1'b0;
        end else if (en) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], win_vld};
            if (win_vld) s1_relu <= cfg_q.relu;
        end
    end

    for (genvar f = 0; f < N_FILT; f++) begin : g_lane
        conv_stream_mf_lane #(
            .PIX_W(PIX_W), .W_W(W_W), .K2(K2), .OUT_W(OUT_W), .SHIFT(SHIFT), .ACC_W(ACC_W)
        ) u_lane (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .ld_s1  (win_vld),
            .ld_s2  (en & vld_pipe[1]),
            .taps   (taps),
            .wts    (cfg_q.k[f]),
            .relu   (s1_relu),
            .y      (y_all[f])
        );
    end

    assign pixel_o     = y_all;
    assign out_valid_o = vld_pipe[STAGES];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ocnt         <= '0;
            frame_done_o <= 1'b0;
        end else begin
            frame_done_o <= hs && (ocnt == OCW'(N_OUT - 1));
            if (hs) ocnt <= (ocnt == OCW'(N_OUT - 1)) ? '0 : ocnt + 1'b1;
        end
    end
endmodule
